speaker_pwm_driver: RTL

// - Output stage after the adaptive FIR. It takes each signed anti-noise sample, applies gain with saturation and converts it to offset-binary PWM duty.
// - A small FIFO holds samples so the duty only changes on a PWM period boundary, never mid-period.
// - Drives the speaker amplifier PWM pin and its shutdown (enable) pin, with a glitch-free mute ramp.

---
 rtl/speaker_pwm_driver.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/speaker_pwm_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | speaker_pwm_driver                                                       |
// | Gain/saturate signed samples, queue them, and play them out as PWM duty  |
// | updated only on period boundaries, with amplifier enable and mute ramp.  |
// | Optional build macro: SPKR_DITHER_EN (LFSR dither before truncation).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module speaker_pwm_driver #(
  parameter int DATA_W     = 16,
  parameter int PWM_W      = 8,
  parameter int PRESCALE   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          ready_in,
  input  logic [DATA_W-1:0]             signal_in,
  input  logic [2:0]                    vol_in,
  input  logic                          mute_in,
  output logic                          pwm_out,
  output logic                          aud_sd_out,
  output logic                          overflow_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int G_W    = DATA_W + 7;
  localparam int FRAC_W = DATA_W - PWM_W;
  localparam logic [PWM_W-1:0]  MID     = {1'b1, {(PWM_W-1){1'b0}}};
  localparam logic [PWM_W-1:0]  CNT_MAX = '1;
  localparam logic [DATA_W-1:0] SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_MUTE = 2'd2
  } state_t;

  // Sample conversion: gain, saturate, optional dither, truncate, offset-binary
  logic signed [G_W-1:0] w_g;
  logic [DATA_W-1:0]     w_gsat;
  logic [DATA_W-1:0]     w_gfin;
  logic [PWM_W-1:0]      w_s;
  logic [PWM_W-1:0]      w_duty;
  logic                  w_unused;

  assign w_g = $signed({{7{signal_in[DATA_W-1]}}, signal_in}) <<< vol_in;

  always_comb begin
    if ((&w_g[G_W-1:DATA_W-1]) || !(|w_g[G_W-1:DATA_W-1])) begin
      w_gsat = w_g[DATA_W-1:0];
    end else if (w_g[G_W-1]) begin
      w_gsat = SAT_NEG;
    end else begin
      w_gsat = SAT_POS;
    end
  end

`ifdef SPKR_DITHER_EN
  logic [15:0]     lfsr_q;
  logic [DATA_W:0] w_dsum;

  assign w_dsum = {w_gsat[DATA_W-1], w_gsat} + {{(PWM_W+1){1'b0}}, lfsr_q[FRAC_W-1:0]};
  // Dither is non-negative, so only a positive overflow is possible
  assign w_gfin = (!w_dsum[DATA_W] && w_dsum[DATA_W-1]) ? SAT_POS : w_dsum[DATA_W-1:0];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lfsr_q <= 16'hACE1;
    end else if (ready_in) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end
`else
  assign w_gfin = w_gsat;
`endif

  assign w_s      = w_gfin[DATA_W-1 -: PWM_W];
  assign w_duty   = {~w_s[PWM_W-1], w_s[PWM_W-2:0]};
  assign w_unused = ^w_gfin[FRAC_W-1:0];

  // PWM timebase
  logic [7:0]       presc_q;
  logic [PWM_W-1:0] cnt_q;
  logic             w_step;
  logic             w_tick;

  assign w_step = (presc_q == 8'(PRESCALE - 1));
  assign w_tick = w_step && (cnt_q == CNT_MAX);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= w_step ? 8'd0 : presc_q + 8'd1;
      if (w_step) begin
        cnt_q <= cnt_q + PWM_W'(1);
      end
    end
  end

  // Sample FIFO
  logic [PWM_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] count_q;
  logic             overflow_q;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  state_t           state_q;

  assign w_full  = (count_q == LVL_W'(FIFO_DEPTH));
  assign w_empty = (count_q == '0);
  assign w_push  = ready_in && !w_full;
  assign w_pop   = w_tick && !w_empty && (state_q != ST_OFF);

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= w_duty;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        count_q <= count_q + LVL_W'(1);
      end else if (!w_push && w_pop) begin
        count_q <= count_q - LVL_W'(1);
      end
      if (ready_in && w_full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Control FSM with level and registered pin outputs
  logic [PWM_W-1:0] level_q;
  logic             pwm_q;
  logic             aud_sd_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= ST_OFF;
      level_q  <= MID;
      pwm_q    <= 1'b0;
      aud_sd_q <= 1'b0;
    end else begin
      pwm_q <= (cnt_q < level_q);
      case (state_q)
        ST_OFF: begin
          level_q <= MID;
          if (!w_empty) begin
            state_q  <= ST_RUN;
            aud_sd_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_pop) begin
            level_q <= mem_q[rd_ptr_q];
          end
          if (mute_in) begin
            state_q <= ST_MUTE;
          end
        end
        ST_MUTE: begin
          if (w_tick) begin
            if (!mute_in) begin
              state_q <= ST_RUN;
              if (!w_empty) begin
                level_q <= mem_q[rd_ptr_q];
              end
            end else if (level_q > MID) begin
              level_q <= level_q - PWM_W'(1);
            end else if (level_q < MID) begin
              level_q <= level_q + PWM_W'(1);
            end
          end
        end
        default: begin
          state_q  <= ST_OFF;
          level_q  <= MID;
          aud_sd_q <= 1'b0;
        end
      endcase
    end
  end

  assign pwm_out        = pwm_q;
  assign aud_sd_out     = aud_sd_q;
  assign overflow_out   = overflow_q;
  assign fifo_level_out = count_q;

endmodule
`default_nettype wire
